// File: rtl/decoder4_scan_seq_pkg.sv
// decoder4_scan_seq_pkg: shared state encodings, default dwell and chan->sel bit reversal
package decoder4_scan_seq_pkg;
   localparam int DWELL_DEF = 4;
   typedef enum logic {ST_IDLE, ST_DWELL} state_e;
   function automatic logic [3:0] bitrev4(input logic [3:0] c);
      return {c[0], c[1], c[2], c[3]};
   endfunction
endpackage

// File: rtl/decoder4_scan_seq_next_chan.sv
// scan_next_chan: lowest enabled channel above cur, else lowest enabled with wrap flag
module scan_next_chan (
   input  logic [15:0] mask_i,
   input  logic [3:0]  cur_i,
   input  logic        from_start_i,
   output logic [3:0]  next_o,
   output logic        found_o,
   output logic        wrapped_o
);
   logic [3:0] hi, lo;
   logic       hi_f, lo_f;
   // descending scan so the lowest qualifying index is written last
   always_comb begin
      hi = 4'd0;
      lo = 4'd0;
      hi_f = 1'b0;
      lo_f = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (mask_i[i]) begin
            lo = 4'(i);
            lo_f = 1'b1;
            if (from_start_i || 4'(i) > cur_i) begin
               hi = 4'(i);
               hi_f = 1'b1;
            end
         end
      end
   end
   assign next_o = hi_f ? hi : lo;
   assign found_o = lo_f;
   assign wrapped_o = lo_f && !hi_f;
endmodule

// File: rtl/decoder4_scan_seq.sv
// decoder4_scan_seq: sweeps enabled channels with a fixed dwell, driving a bit-reversed decoder select
module decoder4_scan_seq
   import decoder4_scan_seq_pkg::*;
#(
   parameter int DWELL = DWELL_DEF,
   parameter int CNTW  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic        continuous_i,
   input  logic [15:0] mask_i,
   input  logic        hold_i,
   output logic [3:0]  sel_o,
   output logic [3:0]  chan_o,
   output logic        sel_valid_o,
   output logic        busy_o,
   output logic        sweep_done_o
);
   localparam logic [CNTW-1:0] LAST = CNTW'(DWELL - 1);
   state_e          state_q, state_d;
   logic [3:0]      chan_q, chan_d, nxt;
   logic            valid_q, valid_d, done_q, done_d, cont_q, cont_d, found, wrapped;
   logic [15:0]     mask_q, mask_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   scan_next_chan u_next (
      .mask_i      (state_q == ST_IDLE ? mask_i : mask_q),
      .cur_i       (chan_q),
      .from_start_i(state_q == ST_IDLE),
      .next_o      (nxt),
      .found_o     (found),
      .wrapped_o   (wrapped)
   );
   // next-state: stop dominates, start only in IDLE, advance after DWELL unheld cycles
   always_comb begin
      state_d = state_q;
      chan_d = chan_q;
      valid_d = valid_q;
      done_d = 1'b0;
      mask_d = mask_q;
      cont_d = cont_q;
      cnt_d = cnt_q;
      if (stop_i) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
         if (start_i) begin
            mask_d = mask_i;
            cont_d = continuous_i;
            done_d = !found;
            if (found) begin
               state_d = ST_DWELL;
               chan_d = nxt;
               valid_d = 1'b1;
               cnt_d = '0;
            end
         end
      end else if (!hold_i) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            done_d = wrapped;
            if (wrapped && !cont_q) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else begin
               chan_d = nxt;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end
   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         chan_q <= 4'd0;
         valid_q <= 1'b0;
         done_q <= 1'b0;
         mask_q <= 16'd0;
         cont_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         chan_q <= chan_d;
         valid_q <= valid_d;
         done_q <= done_d;
         mask_q <= mask_d;
         cont_q <= cont_d;
         cnt_q <= cnt_d;
      end
   end
   assign chan_o = chan_q;
   assign sel_o = bitrev4(chan_q);
   assign sel_valid_o = valid_q;
   assign busy_o = state_q != ST_IDLE;
   assign sweep_done_o = done_q;
endmodule

// File: tb/tb_decoder4_scan_seq.sv
// tb_decoder4_scan_seq: directed self-checking bench for the channel scan sequencer
module tb_decoder4_scan_seq;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cont = 1'b0, hold = 1'b0;
   logic [15:0] mask = 16'd0;
   logic [3:0]  sel, chan;
   logic        valid, busy, done;
   int          checks = 0, passes = 0;
   decoder4_scan_seq #(.DWELL(4), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .continuous_i(cont),
      .mask_i(mask), .hold_i(hold), .sel_o(sel), .chan_o(chan),
      .sel_valid_o(valid), .busy_o(busy), .sweep_done_o(done)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask
   task automatic st(input string tag, input logic v, input logic b, input logic d);
      chk({tag, ".valid"}, 32'(valid), 32'(v));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".done"}, 32'(done), 32'(d));
   endtask
   task automatic ch(input string tag, input logic [3:0] c, input logic [3:0] s);
      logic [3:0]  di;
      logic [15:0] dec;
      chk({tag, ".chan"}, 32'(chan), 32'(c));
      chk({tag, ".sel"}, 32'(sel), 32'(s));
      di = {sel[0], sel[1], sel[2], sel[3]};
      dec = 16'h1 << di;
      if (valid) chk({tag, ".onehot"}, 32'(dec), 32'(16'h1 << c));
   endtask
   initial begin
      logic [3:0] c1[3];
      logic [3:0] s1[3];
      c1 = '{4'd0, 4'd2, 4'd8};
      s1 = '{4'h0, 4'h4, 4'h1};
      tick();
      tick();
      st("rst", 0, 0, 0);
      ch("rst", 4'd0, 4'h0);
      rst = 1'b0;
      mask = 16'h0105;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 4; j++) begin
            st("t1", 1, 1, 0);
            ch("t1", c1[k], s1[k]);
            tick();
         end
      st("t1end", 0, 0, 1);
      ch("t1end", 4'd8, 4'h1);
      tick();
      st("t1post", 0, 0, 0);
      mask = 16'h8001;
      cont = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int s = 0; s < 24; s++) begin
         st("t2", 1, 1, s > 0 && s % 8 == 0);
         ch("t2", (s / 4) % 2 ? 4'd15 : 4'd0, (s / 4) % 2 ? 4'hF : 4'h0);
         tick();
      end
      st("t2wrap", 1, 1, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      st("t2stop", 0, 0, 0);
      cont = 1'b0;
      mask = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      st("t3", 0, 0, 1);
      tick();
      st("t3post", 0, 0, 0);
      mask = 16'h0010;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int s = 0; s < 7; s++) begin
         st("t4", 1, 1, 0);
         ch("t4", 4'd4, 4'h2);
         hold = s >= 1 && s <= 3;
         tick();
      end
      st("t4end", 0, 0, 1);
      mask = 16'h00F0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ch("t5a", 4'd4, 4'h2);
      repeat (4) tick();
      st("t5b", 1, 1, 0);
      ch("t5b", 4'd5, 4'hA);
      tick();
      start = 1'b1;
      mask = 16'h0001;
      tick();
      start = 1'b0;
      st("t5busy", 1, 1, 0);
      ch("t5busy", 4'd5, 4'hA);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      st("t5stop", 0, 0, 0);
      ch("t5stop", 4'd5, 4'hA);
      tick();
      st("t5post", 0, 0, 0);
      stop = 1'b1;
      start = 1'b1;
      mask = 16'h000F;
      tick();
      stop = 1'b0;
      start = 1'b0;
      st("t5ss", 0, 0, 0);
      mask = 16'h0006;
      cont = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      st("t6run", 1, 1, 0);
      ch("t6run", 4'd1, 4'h8);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      st("t6rst", 0, 0, 0);
      ch("t6rst", 4'd0, 4'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
